mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_ctrl.sv | 119 +++++++++++
 tb/tb_mult_div_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// rtl/mult_div_ctrl.sv - multi-cycle HI/LO multiply/divide unit with fixed busy latency
module mult_div_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MULT_RUN = 2'd1;
  localparam logic [1:0] DIV_RUN  = 2'd2;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic             signed_q;

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] divisor;
  logic [31:0] uquo;
  logic [31:0] urem;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_zero;

  // Sign/zero extension to 64 bits lets one truncated multiplier serve mult and multu.
  assign ext_a = signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign ext_b = signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = ext_a * ext_b;

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign abs_a    = (signed_q && a_q[31]) ? -a_q : a_q;
  assign abs_b    = (signed_q && b_q[31]) ? -b_q : b_q;
  assign div_zero = (b_q == 32'd0);
  assign divisor  = div_zero ? 32'd1 : abs_b;
  assign uquo     = abs_a / divisor;
  assign urem     = abs_a % divisor;
  assign quo      = (signed_q && (a_q[31] ^ b_q[31])) ? -uquo : uquo;
  assign rem      = (signed_q && a_q[31]) ? -urem : urem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      signed_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op)
              3'd0, 3'd1: begin
                a_q      <= src_a;
                b_q      <= src_b;
                signed_q <= ~md_op[0];
                cnt      <= CNT_W'(MULT_CYCLES);
                busy     <= 1'b1;
                state    <= MULT_RUN;
              end
              3'd2, 3'd3: begin
                a_q      <= src_a;
                b_q      <= src_b;
                signed_q <= ~md_op[0];
                cnt      <= CNT_W'(DIV_CYCLES);
                busy     <= 1'b1;
                state    <= DIV_RUN;
              end
              3'd4:    hi <= src_a;
              3'd5:    lo <= src_a;
              default: ;
            endcase
          end
        end
        MULT_RUN, DIV_RUN: begin
          if (cnt <= CNT_W'(1)) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
            if (state == MULT_RUN) begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end else if (!div_zero) begin
              hi <= rem;
              lo <= quo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb/tb_mult_div_ctrl.sv - directed and random checks of mult_div_ctrl against an arithmetic model
module tb_mult_div_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of each op on HI/LO, from plain 64-bit arithmetic.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      3'd0: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      3'd1: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd2: if (b != 0) begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue a mult/div, optionally inject a mult start at busy cycle inj, and check timing and result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
    int n;
    n = (op < 3'd2) ? MC : DC;
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    step();
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    check("accept_busy", {63'd0, busy}, 64'd1);
    check("accept_done", {63'd0, done}, 64'd0);
    for (int k = 1; k < n; k++) begin
      if (k == inj) begin
        start = 1'b1; md_op = 3'd0; src_a = 32'd2; src_b = 32'd2;
      end
      step();
      start = 1'b0;
      check("run_busy", {63'd0, busy}, 64'd1);
      check("run_done", {63'd0, done}, 64'd0);
      check("run_hilo", {hi, lo}, {m_hi, m_lo});
    end
    step();
    model_apply(op, a, b);
    check("end_busy", {63'd0, busy}, 64'd0);
    check("end_done", {63'd0, done}, 64'd1);
    check("end_hi", {32'd0, hi}, {32'd0, m_hi});
    check("end_lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  task automatic idle_op(input logic [2:0] op, input logic [31:0] a);
    start = 1'b1; md_op = op; src_a = a; src_b = $urandom;
    step();
    start = 1'b0;
    model_apply(op, a, 32'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_done", {63'd0, done}, 64'd0);
    check("idle_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; start = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    step();
    step();
    reset = 1'b0;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    run_op(3'd0, 32'hFFFFFFFE, 32'd3, -1);
    check("mult_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    check("multu_max_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, -1);
    check("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd3, 32'd7, 32'd0, -1);
    check("divu_zero_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, -1);
    check("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

    idle_op(3'd4, 32'h12345678);
    check("mthi_hi", {32'd0, hi}, 64'h12345678);
    run_op(3'd2, 32'd100, 32'd7, 2);
    check("div_inject_hilo", {hi, lo}, 64'h00000002_0000000E);
    idle_op(3'd5, 32'hCAFEF00D);
    idle_op(3'd6, 32'h55555555);
    idle_op(3'd7, 32'hAAAAAAAA);

    // Reset in the third busy cycle of a mult aborts it.
    start = 1'b1; md_op = 3'd0; src_a = 32'd9; src_b = 32'd9;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    for (int k = 0; k < MC + 2; k++) begin
      step();
      check("abort_no_done", {63'd0, done}, 64'd0);
      check("abort_hilo_hold", {hi, lo}, 64'd0);
    end

    // Back-to-back: each run_op issues in the done cycle of the previous one.
    run_op(3'd0, 32'd6, 32'd7, -1);
    run_op(3'd0, 32'hFFFF0000, 32'h00010001, -1);
    run_op(3'd1, 32'h89ABCDEF, 32'h01234567, -1);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
      if (op < 3'd4) run_op(op, a, b, ($urandom_range(0, 3) == 0) ? 1 : -1);
      else idle_op(op, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
